// File: rtl/heap_pq.sv
// heap_pq: binary-heap priority queue with a multi-cycle sift FSM.
// One compare-and-swap per clock keeps the critical path to a single
// comparator. Commands use a ready/valid handshake; the removed root of a
// POP/REPLACE comes back as a one-cycle rsp_valid pulse.
module heap_pq #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int MIN_HEAP = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [1:0]                 cmd_op,
    input  logic [DATA_W-1:0]          cmd_data,
    output logic                       rsp_valid,
    output logic [DATA_W-1:0]          rsp_data,
    output logic                       top_valid,
    output logic [DATA_W-1:0]          top_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       err
);
    // Array address width, count width, and a wider node-index width so that
    // 2*idx+2 never wraps even when DEPTH is a power of two.
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int IW = $clog2(DEPTH) + 2;

    localparam logic [1:0] OP_CLEAR   = 2'd0;
    localparam logic [1:0] OP_PUSH    = 2'd1;
    localparam logic [1:0] OP_POP     = 2'd2;

    typedef enum logic [1:0] {IDLE, SIFT_UP, SIFT_DOWN} state_t;

    state_t            state_reg;
    logic [DATA_W-1:0] arr_reg [DEPTH];
    logic [IW-1:0]     idx_reg;
    logic [CW-1:0]     count_reg;
    logic              ready_reg;

    // Strict ordering: equal keys are never considered better, so they never swap.
    function automatic logic better(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        if (MIN_HEAP != 0)
            return a < b;
        else
            return a > b;
    endfunction

    logic [IW-1:0]     cnt_w;
    logic [IW-1:0]     par_idx;
    logic [IW-1:0]     lft_idx;
    logic [IW-1:0]     rgt_idx;
    logic [IW-1:0]     chd_idx;
    logic [DATA_W-1:0] cur_val;
    logic [DATA_W-1:0] par_val;
    logic [DATA_W-1:0] lft_val;
    logic [DATA_W-1:0] rgt_val;
    logic [DATA_W-1:0] chd_val;
    logic              has_left;

    // Neighbour indices of the current node and the better child for sift-down.
    // Out-of-range reads are harmless: they are only used when guarded by count.
    always_comb begin
        cnt_w    = IW'(count_reg);
        par_idx  = (idx_reg - IW'(1)) >> 1;
        lft_idx  = (idx_reg << 1) + IW'(1);
        rgt_idx  = lft_idx + IW'(1);
        cur_val  = arr_reg[AW'(idx_reg)];
        par_val  = arr_reg[AW'(par_idx)];
        lft_val  = arr_reg[AW'(lft_idx)];
        rgt_val  = arr_reg[AW'(rgt_idx)];
        has_left = lft_idx < cnt_w;
        chd_idx  = lft_idx;
        chd_val  = lft_val;
        if ((rgt_idx < cnt_w) && better(rgt_val, lft_val)) begin
            chd_idx = rgt_idx;
            chd_val = rgt_val;
        end
    end

    // Command decode and sift FSM; ready is registered so it never depends
    // combinationally on cmd_*.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            count_reg <= '0;
            ready_reg <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            err       <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                arr_reg[i] <= '0;
        end else begin
            rsp_valid <= 1'b0;
            err       <= 1'b0;
            case (state_reg)
                IDLE: begin
                    ready_reg <= 1'b1;
                    if (cmd_valid && ready_reg) begin
                        if (cmd_op == OP_CLEAR) begin
                            count_reg <= '0;
                        end else if (cmd_op == OP_PUSH) begin
                            if (count_reg == CW'(DEPTH)) begin
                                err <= 1'b1;
                            end else begin
                                arr_reg[AW'(count_reg)] <= cmd_data;
                                count_reg <= count_reg + CW'(1);
                                if (count_reg != '0) begin
                                    state_reg <= SIFT_UP;
                                    idx_reg   <= cnt_w;
                                    ready_reg <= 1'b0;
                                end
                            end
                        end else if (count_reg == '0) begin
                            err <= 1'b1;
                        end else begin
                            rsp_valid <= 1'b1;
                            rsp_data  <= arr_reg[0];
                            idx_reg   <= '0;
                            if (cmd_op == OP_POP) begin
                                arr_reg[0] <= arr_reg[AW'(count_reg - CW'(1))];
                                count_reg  <= count_reg - CW'(1);
                                if (count_reg > CW'(2)) begin
                                    state_reg <= SIFT_DOWN;
                                    ready_reg <= 1'b0;
                                end
                            end else begin
                                arr_reg[0] <= cmd_data;
                                if (count_reg > CW'(1)) begin
                                    state_reg <= SIFT_DOWN;
                                    ready_reg <= 1'b0;
                                end
                            end
                        end
                    end
                end
                SIFT_UP: begin
                    if (better(cur_val, par_val)) begin
                        arr_reg[AW'(par_idx)] <= cur_val;
                        arr_reg[AW'(idx_reg)] <= par_val;
                        idx_reg <= par_idx;
                        if (par_idx == '0) begin
                            state_reg <= IDLE;
                            ready_reg <= 1'b1;
                        end
                    end else begin
                        state_reg <= IDLE;
                        ready_reg <= 1'b1;
                    end
                end
                SIFT_DOWN: begin
                    if (has_left && better(chd_val, cur_val)) begin
                        arr_reg[AW'(chd_idx)] <= cur_val;
                        arr_reg[AW'(idx_reg)] <= chd_val;
                        idx_reg <= chd_idx;
                    end else begin
                        state_reg <= IDLE;
                        ready_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign cmd_ready = ready_reg;
    assign top_valid = ready_reg && (count_reg != '0);
    assign top_data  = arr_reg[0];
    assign count     = count_reg;
    assign full      = (count_reg == CW'(DEPTH));
    assign empty     = (count_reg == '0);

endmodule

// File: tb/tb_heap_pq.sv
// tb_heap_pq: directed test of heap_pq using three instances:
// 0 = max-heap DEPTH 32, 1 = min-heap DEPTH 8, 2 = max-heap DEPTH 4.
module tb_heap_pq;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [2:0]       cmd_valid;
    logic [2:0][1:0]  cmd_op;
    logic [2:0][31:0] cmd_data;
    logic [2:0]       cmd_ready, rsp_valid, top_valid, full, empty, err;
    logic [2:0][31:0] rsp_data, top_data;
    logic [5:0]       count0;
    logic [3:0]       count1;
    logic [2:0]       count2;
    logic [2:0][5:0]  cnt;

    assign cnt[0] = count0;
    assign cnt[1] = {2'b00, count1};
    assign cnt[2] = {3'b000, count2};

    int checks = 0;
    int errors = 0;

    heap_pq #(.DATA_W(32), .DEPTH(32), .MIN_HEAP(0)) u_max (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_op(cmd_op[0]), .cmd_data(cmd_data[0]),
        .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]), .top_valid(top_valid[0]), .top_data(top_data[0]),
        .count(count0), .full(full[0]), .empty(empty[0]), .err(err[0]));

    heap_pq #(.DATA_W(32), .DEPTH(8), .MIN_HEAP(1)) u_min (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_op(cmd_op[1]), .cmd_data(cmd_data[1]),
        .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]), .top_valid(top_valid[1]), .top_data(top_data[1]),
        .count(count1), .full(full[1]), .empty(empty[1]), .err(err[1]));

    heap_pq #(.DATA_W(32), .DEPTH(4), .MIN_HEAP(0)) u_small (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid[2]), .cmd_ready(cmd_ready[2]), .cmd_op(cmd_op[2]), .cmd_data(cmd_data[2]),
        .rsp_valid(rsp_valid[2]), .rsp_data(rsp_data[2]), .top_valid(top_valid[2]), .top_data(top_data[2]),
        .count(count2), .full(full[2]), .empty(empty[2]), .err(err[2]));

    // Present one command, hold it until accepted, return the outputs seen
    // just after the accepting edge.
    task automatic issue(input int k, input logic [1:0] op, input logic [31:0] d,
                         output logic rv, output logic [31:0] rd, output logic er);
        int n;
        @(negedge clk);
        cmd_valid[k] = 1'b1;
        cmd_op[k]    = op;
        cmd_data[k]  = d;
        n = 0;
        while (cmd_ready[k] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL accept_timeout inst%0d: cmd_ready=%b required 1", k, cmd_ready[k]);
        end
        @(posedge clk);
        #1;
        cmd_valid[k] = 1'b0;
        rv = rsp_valid[k];
        rd = rsp_data[k];
        er = err[k];
    endtask

    task automatic wait_idle(input int k);
        int n;
        n = 0;
        while (cmd_ready[k] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL idle_timeout inst%0d: cmd_ready=%b required 1", k, cmd_ready[k]);
        end
    endtask

    task automatic push(input int k, input logic [31:0] d);
        logic rv, er;
        logic [31:0] rd;
        issue(k, 2'd1, d, rv, rd, er);
        wait_idle(k);
    endtask

    task automatic clear(input int k);
        logic rv, er;
        logic [31:0] rd;
        issue(k, 2'd0, 32'd0, rv, rd, er);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (cnt[k] !== 6'd0 || empty[k] !== 1'b1 || rsp_valid[k] !== 1'b0 || err[k] !== 1'b0 ||
                top_valid[k] !== 1'b0 || rsp_data[k] !== 32'd0) begin
                errors++;
                $display("FAIL reset_state inst%0d: count=%0d empty=%b rsp_valid=%b err=%b top_valid=%b rsp_data=%0d required 0,1,0,0,0,0",
                         k, cnt[k], empty[k], rsp_valid[k], err[k], top_valid[k], rsp_data[k]);
            end
        end
        reset = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 3'b000) begin
            errors++;
            $display("FAIL ready_before_edge: cmd_ready=%b required 000", cmd_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (cmd_ready !== 3'b111) begin
            errors++;
            $display("FAIL ready_after_edge: cmd_ready=%b required 111", cmd_ready);
        end
        $display("test_reset done");
    endtask

    task automatic test_max_order;
        logic rv, er;
        logic [31:0] rd;
        logic [31:0] vals [5];
        logic [31:0] exp_pop [5];
        vals    = '{32'd5, 32'd3, 32'd9, 32'd1, 32'd7};
        exp_pop = '{32'd9, 32'd7, 32'd5, 32'd3, 32'd1};
        for (int i = 0; i < 5; i++) push(0, vals[i]);
        checks++;
        if (cnt[0] !== 6'd5 || top_data[0] !== 32'd9 || top_valid[0] !== 1'b1) begin
            errors++;
            $display("FAIL max_after_push: count=%0d top=%0d top_valid=%b required 5,9,1", cnt[0], top_data[0], top_valid[0]);
        end
        for (int i = 0; i < 5; i++) begin
            issue(0, 2'd2, 32'd0, rv, rd, er);
            checks++;
            if (rv !== 1'b1 || rd !== exp_pop[i] || er !== 1'b0 || cnt[0] !== 6'(4 - i)) begin
                errors++;
                $display("FAIL max_pop%0d: rsp_valid=%b rsp_data=%0d err=%b count=%0d required 1,%0d,0,%0d",
                         i, rv, rd, er, cnt[0], exp_pop[i], 4 - i);
            end
            $display("max pop %0d -> %0d", i, rd);
            wait_idle(0);
        end
        checks++;
        if (empty[0] !== 1'b1 || top_valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL max_empty: empty=%b top_valid=%b required 1,0", empty[0], top_valid[0]);
        end
    endtask

    task automatic test_min_order;
        logic rv, er;
        logic [31:0] rd;
        logic [31:0] vals [4];
        logic [31:0] exp_pop [4];
        vals    = '{32'd40, 32'd10, 32'd30, 32'd20};
        exp_pop = '{32'd10, 32'd20, 32'd30, 32'd40};
        for (int i = 0; i < 4; i++) push(1, vals[i]);
        checks++;
        if (top_data[1] !== 32'd10 || cnt[1] !== 6'd4) begin
            errors++;
            $display("FAIL min_top: top=%0d count=%0d required 10,4", top_data[1], cnt[1]);
        end
        for (int i = 0; i < 4; i++) begin
            issue(1, 2'd2, 32'd0, rv, rd, er);
            checks++;
            if (rv !== 1'b1 || rd !== exp_pop[i] || er !== 1'b0) begin
                errors++;
                $display("FAIL min_pop%0d: rsp_valid=%b rsp_data=%0d err=%b required 1,%0d,0", i, rv, rd, er, exp_pop[i]);
            end
            $display("min pop %0d -> %0d", i, rd);
            wait_idle(1);
        end
    endtask

    task automatic test_full_empty_err;
        logic rv, er;
        logic [31:0] rd;
        for (int i = 1; i <= 4; i++) push(2, 32'(i));
        issue(2, 2'd1, 32'd5, rv, rd, er);
        checks++;
        if (er !== 1'b1 || rv !== 1'b0 || cnt[2] !== 6'd4 || full[2] !== 1'b1) begin
            errors++;
            $display("FAIL push_full: err=%b rsp_valid=%b count=%0d full=%b required 1,0,4,1", er, rv, cnt[2], full[2]);
        end
        @(posedge clk);
        #1;
        checks++;
        if (err[2] !== 1'b0) begin
            errors++;
            $display("FAIL err_pulse_width: err=%b required 0", err[2]);
        end
        for (int i = 0; i < 4; i++) begin
            issue(2, 2'd2, 32'd0, rv, rd, er);
            checks++;
            if (rd !== 32'(4 - i) || rv !== 1'b1) begin
                errors++;
                $display("FAIL small_pop%0d: rsp_data=%0d rsp_valid=%b required %0d,1", i, rd, rv, 4 - i);
            end
            wait_idle(2);
        end
        issue(2, 2'd2, 32'd0, rv, rd, er);
        checks++;
        if (er !== 1'b1 || rv !== 1'b0 || cnt[2] !== 6'd0 || empty[2] !== 1'b1) begin
            errors++;
            $display("FAIL pop_empty: err=%b rsp_valid=%b count=%0d empty=%b required 1,0,0,1", er, rv, cnt[2], empty[2]);
        end
        $display("full/empty error checks done");
    endtask

    task automatic test_replace_clear;
        logic rv, er;
        logic [31:0] rd;
        push(0, 32'd8);
        push(0, 32'd6);
        push(0, 32'd4);
        issue(0, 2'd3, 32'd5, rv, rd, er);
        checks++;
        if (rv !== 1'b1 || rd !== 32'd8 || er !== 1'b0 || cnt[0] !== 6'd3) begin
            errors++;
            $display("FAIL replace3: rsp_valid=%b rsp_data=%0d err=%b count=%0d required 1,8,0,3", rv, rd, er, cnt[0]);
        end
        wait_idle(0);
        checks++;
        if (top_data[0] !== 32'd6) begin
            errors++;
            $display("FAIL replace3_top: top=%0d required 6", top_data[0]);
        end
        issue(0, 2'd0, 32'd0, rv, rd, er);
        checks++;
        if (rv !== 1'b0 || cnt[0] !== 6'd0 || empty[0] !== 1'b1 || cmd_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL clear: rsp_valid=%b count=%0d empty=%b ready=%b required 0,0,1,1", rv, cnt[0], empty[0], cmd_ready[0]);
        end
        push(0, 32'd6);
        issue(0, 2'd3, 32'd2, rv, rd, er);
        checks++;
        if (rv !== 1'b1 || rd !== 32'd6 || cmd_ready[0] !== 1'b1 || top_data[0] !== 32'd2 || top_valid[0] !== 1'b1) begin
            errors++;
            $display("FAIL replace1: rsp_valid=%b rsp_data=%0d ready=%b top=%0d top_valid=%b required 1,6,1,2,1",
                     rv, rd, cmd_ready[0], top_data[0], top_valid[0]);
        end
        $display("replace/clear done");
    endtask

    task automatic test_hold_and_reset;
        logic rv, er;
        logic [31:0] rd;
        int n;
        clear(0);
        for (int v = 10; v >= 2; v--) push(0, 32'(v));
        issue(0, 2'd2, 32'd0, rv, rd, er);
        checks++;
        if (rd !== 32'd10 || cmd_ready[0] !== 1'b0) begin
            errors++;
            $display("FAIL pop_sift_down: rsp_data=%0d ready=%b required 10,0", rd, cmd_ready[0]);
        end
        cmd_valid[0] = 1'b1;
        cmd_op[0]    = 2'd1;
        cmd_data[0]  = 32'd100;
        @(negedge clk);
        checks++;
        if (cmd_ready[0] !== 1'b0 || cnt[0] !== 6'd8) begin
            errors++;
            $display("FAIL held_not_accepted: ready=%b count=%0d required 0,8", cmd_ready[0], cnt[0]);
        end
        n = 0;
        while (cmd_ready[0] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        cmd_valid[0] = 1'b0;
        checks++;
        if (cnt[0] !== 6'd9) begin
            errors++;
            $display("FAIL held_accepted: count=%0d required 9", cnt[0]);
        end
        wait_idle(0);
        checks++;
        if (cnt[0] !== 6'd9 || top_data[0] !== 32'd100) begin
            errors++;
            $display("FAIL held_once: count=%0d top=%0d required 9,100", cnt[0], top_data[0]);
        end
        issue(0, 2'd1, 32'd200, rv, rd, er);
        checks++;
        if (cmd_ready[0] !== 1'b0) begin
            errors++;
            $display("FAIL sift_up_busy: ready=%b required 0", cmd_ready[0]);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (cnt[0] !== 6'd0 || top_valid[0] !== 1'b0 || empty[0] !== 1'b1 || cmd_ready[0] !== 1'b0) begin
            errors++;
            $display("FAIL mid_sift_reset: count=%0d top_valid=%b empty=%b ready=%b required 0,0,1,0",
                     cnt[0], top_valid[0], empty[0], cmd_ready[0]);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        push(0, 32'd7);
        checks++;
        if (top_data[0] !== 32'd7 || top_valid[0] !== 1'b1 || cnt[0] !== 6'd1) begin
            errors++;
            $display("FAIL push_after_reset: top=%0d top_valid=%b count=%0d required 7,1,1", top_data[0], top_valid[0], cnt[0]);
        end
        $display("hold/reset done");
    endtask

    task automatic test_duplicates;
        logic rv, er;
        logic [31:0] rd;
        clear(0);
        push(0, 32'd5);
        for (int i = 0; i < 2; i++) begin
            issue(0, 2'd1, 32'd5, rv, rd, er);
            @(posedge clk);
            #1;
            checks++;
            if (cmd_ready[0] !== 1'b1) begin
                errors++;
                $display("FAIL dup_sift_one_compare%0d: ready=%b required 1", i, cmd_ready[0]);
            end
            wait_idle(0);
        end
        for (int i = 0; i < 3; i++) begin
            issue(0, 2'd2, 32'd0, rv, rd, er);
            checks++;
            if (rv !== 1'b1 || rd !== 32'd5 || er !== 1'b0) begin
                errors++;
                $display("FAIL dup_pop%0d: rsp_valid=%b rsp_data=%0d err=%b required 1,5,0", i, rv, rd, er);
            end
            $display("dup pop %0d -> %0d", i, rd);
            wait_idle(0);
        end
        checks++;
        if (empty[0] !== 1'b1) begin
            errors++;
            $display("FAIL dup_empty: empty=%b required 1", empty[0]);
        end
    endtask

    initial begin
        cmd_valid = '0;
        cmd_op    = '0;
        cmd_data  = '0;
        test_reset();
        test_max_order();
        test_min_order();
        test_full_empty_err();
        test_replace_clear();
        test_hold_and_reset();
        test_duplicates();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/heap_pq.md
Name: heap_pq

Overview:
Parametrised, multi-cycle binary-heap priority queue, the successor to the single-cycle heap_module.
- Heap order is restored by a sift-up/sift-down FSM doing one compare-and-swap per clock, so the critical path is one comparator, not a whole-array loop.
- Adds a ready/valid command handshake, selectable min/max ordering, a combined pop+push (replace) operation, and error flagging.
- Serves as the scheduling/priority queue feeding downstream dispatch logic.

Parameters:
DATA_W, 32, key width in bits (unsigned compare).
DEPTH, 32, maximum entries; must be at least 2; need not be a power of two.
MIN_HEAP, 0, 0 = max-heap (largest at root), 1 = min-heap (smallest at root).

Ports:
clk  in  1  single clock, rising edge.
reset  in  1  asynchronous, active-high reset.
cmd_valid  in  1  command present.
cmd_ready  out  1  block can accept a command; high only in IDLE.
cmd_op  in  2  0 CLEAR, 1 PUSH, 2 POP, 3 REPLACE.
cmd_data  in  DATA_W  key for PUSH/REPLACE.
rsp_valid  out  1  one-cycle pulse carrying the removed root.
rsp_data  out  DATA_W  removed root value.
top_valid  out  1  high when IDLE and count>0.
top_data  out  DATA_W  current root (arr[0]); meaningful only when top_valid.
count  out  $clog2(DEPTH+1)  number of entries.
full  out  1  count==DEPTH.
empty  out  1  count==0.
err  out  1  one-cycle pulse on an illegal command.

Behaviour:
- Reset (async, any state, including mid-sift): FSM->IDLE; count=0; rsp_valid=0; rsp_data=0; err=0; all array entries=0. cmd_ready=1 from the first clock edge after reset deasserts.
- "better(a,b)": a>b if MIN_HEAP=0, a<b if MIN_HEAP=1; strict, so equal keys never swap.
- Accept = cmd_valid && cmd_ready. Commands presented when not ready are held by the source and are not lost or sampled.
- States: IDLE, SIFT_UP, SIFT_DOWN; idx register holds the current node.
- CLEAR (accepted): count<=0 next cycle, stay IDLE. Array contents are don't-care. No rsp_valid.
- PUSH, not full:
  - arr[count]<=cmd_data; count<=count+1.
  - If old count==0, stay IDLE; else ->SIFT_UP with idx=old count.
- PUSH, full: err pulse next cycle, no state change, stay IDLE.
- SIFT_UP, each cycle, p=(idx-1)>>1:
  - if better(arr[idx],arr[p]): swap, idx<=p; go IDLE when p==0.
  - else: ->IDLE.
- POP, not empty:
  - rsp_valid=1 and rsp_data=old arr[0] on the cycle after accept.
  - arr[0]<=arr[count-1]; count<=count-1.
  - If new count>1, ->SIFT_DOWN with idx=0; else IDLE.
- REPLACE, not empty:
  - rsp_valid/rsp_data as for POP.
  - arr[0]<=cmd_data; count unchanged.
  - If count>1, ->SIFT_DOWN with idx=0; else IDLE.
- POP or REPLACE, empty: err pulse next cycle, no rsp_valid, state unchanged.
- SIFT_DOWN, each cycle, l=2*idx+1, r=l+1:
  - c=l if l<count, else ->IDLE.
  - If r<count and better(arr[r],arr[l]), c=r; a tie selects l.
  - If better(arr[c],arr[idx]): swap, idx<=c. Else ->IDLE.
- Latency:
  - PUSH/POP/REPLACE busy for at most floor(log2(count))+1 cycles after accept; CLEAR busy for 0 cycles.
  - Back-to-back commands are possible only when no sift is needed.
- full/empty/count are registered and update the cycle after accept.
- Index arithmetic uses at least $clog2(DEPTH)+1 bits so that 2*idx+2 cannot wrap.
- Only one compare-and-swap per cycle. No combinational path from cmd_* to cmd_ready.

Test Plan:
- Max-heap, push 5,3,9,1,7, then pop five times -> rsp_data 9,7,5,3,1, count 5->0, empty=1, no err.
- MIN_HEAP=1, push 40,10,30,20, then pop four times -> rsp_data 10,20,30,40. top_data=10 after the pushes settle.
- DEPTH=4, push 1,2,3,4,5 -> fifth push gives err pulse, count stays 4, full=1. Then pop from empty -> err pulse, no rsp_valid.
- Max-heap {8,6,4}, REPLACE with 5 -> rsp_data 8, count=3, top_data 6 after settle. Then REPLACE on one entry {6} with 2 -> rsp 6, top 2, cmd_ready back in one cycle.
- Hold cmd_valid with PUSH 100 during a SIFT_DOWN -> cmd_ready=0 and the command is not accepted until IDLE, then accepted once. Next, assert reset mid-SIFT_UP -> count=0, IDLE, top_valid=0, next push 7 gives top_data 7.
- Duplicates: push 5,5,5 then pop three times -> 5,5,5, no spurious swaps (SIFT_UP exits after one compare).
